freq_div_ctrl: RTL and testbench
================================

Name: freq_div_ctrl

Overview:
- Run-time controller and divider core for keyboard/light-box clock generation.
- Replaces fixed-coefficient division with a programmable half-period, loaded through a valid/ready handshake.
- Start/stop sequencing is glitch-free: stop always parks the output at its idle-high level.
- New coefficients take effect only at output toggle boundaries.

Parameters:
- CNTR_WIDTH, 8, width of the half-period register and counter.
- DEFAULT_HALF, 2, half-period in clk cycles after reset. Must be nonzero and less than 2^CNTR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset. Asserted at 0.
- start  in  1  level-sampled request to run.
- stop  in  1  level-sampled request to stop.
- cfg_valid  in  1  new half-period offered.
- cfg_half  in  CNTR_WIDTH  half-period in clk cycles.
- cfg_ready  out  1  controller can accept cfg.
- cfg_err  out  1  one-cycle pulse when cfg_half==0 is rejected.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the clk cycle clk_out toggles.
- running  out  1  high in RUN and STOPPING.

Behaviour:
- Reset values (rst=0):
  - state=IDLE, clk_out=1, cntr=0, half_q=DEFAULT_HALF.
  - No update pending.
  - cfg_ready=1, cfg_err=0, tick=0, running=0.
- States: IDLE, RUN, STOPPING.
- Counting (RUN/STOPPING):
  - cntr increments each cycle.
  - When cntr==half_q-1: clk_out inverts, cntr<=0, tick=1 that cycle ("boundary").
  - clk_out period = 2*half_q clk cycles, 50% duty.
  - half_q=1 gives clk/2.
- IDLE: cntr held at 0, clk_out held at 1.
- IDLE->RUN: on start=1 && stop=0. Counting begins the next cycle; the first (falling) toggle occurs half_q cycles after entering RUN.
- RUN->STOPPING: on stop=1. stop has priority over start when both are high.
- STOPPING:
  - Counting continues.
  - At the boundary that drives clk_out 0->1: go to IDLE, cntr=0.
  - If clk_out is 1 when stop is seen, the full low phase completes first. Output is never shortened.
- STOPPING->RUN: on start=1 && stop=0 before the stopping boundary. Counting is undisturbed.
- Config handshake (transfer = cfg_valid && cfg_ready):
  - cfg_half==0: rejected, cfg_err=1 for one cycle, nothing changes. cfg_ready stays 1.
  - In IDLE: half_q<=cfg_half on the transfer edge.
  - In RUN/STOPPING:
    - Value is latched into pend_q, pend_v=1, and cfg_ready drops to 0 the next cycle.
    - At the next boundary, half_q<=pend_q and pend_v<=0. cfg_ready returns to 1 the cycle after.
    - A transfer on the same cycle as a boundary is applied at the following boundary, not the current one.
  - An update pending when STOPPING reaches IDLE is applied on that final boundary.
- cfg_ready = !pend_v.
- Width rule: cntr and half_q are CNTR_WIDTH bits unsigned. Comparison uses half_q-1, with no wrap because half_q is never 0.
- Async reset mid-run: immediate return to reset values. Any pending update is discarded.

Optional Feature:
- Macro: FDC_PERIOD_CNT_EN.
- Defined:
  - Adds output port period_cnt (out, 16 bits), reset 0.
  - Increments on every rising clk_out toggle (0->1 boundary) in RUN/STOPPING.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared to 0 on the IDLE->RUN transition.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then start=1 with DEFAULT_HALF=2 -> clk_out falls 2 cycles after RUN entry, then toggles every 2 cycles; tick pulses align with each toggle; running=1.
- In IDLE, cfg_half=5 accepted, then start -> period 10 clk cycles. cfg_half=0 -> cfg_err one-cycle pulse, half_q unchanged, cfg_ready stays 1.
- While running with half_q=3, transfer cfg_half=1 mid-phase:
  - cfg_ready=0 until the next boundary.
  - The old phase completes at 3 cycles; subsequent phases last 1 cycle.
  - cfg_ready=1 one cycle after the boundary.
- stop asserted while clk_out=1 (half_q=4) -> output completes a 4-cycle low phase, rises, state IDLE, running=0, clk_out stays 1. Repeat with stop while low -> stops at the next rising edge.
- start and stop high together in IDLE -> remains IDLE. In STOPPING, start alone -> returns to RUN with no phase disturbance.
- rst=0 mid-phase with a pending cfg -> all outputs at reset values immediately; after release, half_q=DEFAULT_HALF. With FDC_PERIOD_CNT_EN: 3 full periods after start -> period_cnt=3; restart clears it to 0.

Source files
------------

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run-time programmable clock divider with glitch-free
// start/stop sequencing and a valid/ready coefficient load port.
// clk_out period is 2*half_q clk cycles; stop always parks clk_out high.
// Optional build macro FDC_PERIOD_CNT_EN adds a 16-bit rising-edge counter
// output (period_cnt); without it the port and its logic are absent.
module freq_div_ctrl #(
    parameter int unsigned CNTR_WIDTH   = 8,
    parameter int unsigned DEFAULT_HALF = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_valid,
    input  logic [CNTR_WIDTH-1:0] cfg_half,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    output logic                  clk_out,
`ifdef FDC_PERIOD_CNT_EN
    output logic [15:0]           period_cnt,
`endif
    output logic                  tick,
    output logic                  running
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNTR_WIDTH-1:0] cntr;
    logic [CNTR_WIDTH-1:0] half_q;
    logic [CNTR_WIDTH-1:0] pend_q;
    logic                  pend_v;
    logic                  clk_out_q;
    logic                  cfg_err_q;

    logic                  counting;
    logic                  boundary;
    logic                  rising;
    logic                  xfer;
    logic                  accept;

    // Phase boundary and handshake decode shared by FSM and datapath
    always_comb begin
        counting = (state != IDLE);
        boundary = counting && (cntr == (half_q - CNTR_WIDTH'(1)));
        rising   = boundary && !clk_out_q;
        xfer     = cfg_valid && !pend_v;
        accept   = xfer && (cfg_half != '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; stop outranks start, STOPPING parks only on a rising boundary
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !stop) state_next = RUN;
            end
            RUN: begin
                if (stop) state_next = STOPPING;
            end
            STOPPING: begin
                if (start && !stop) state_next = RUN;
                else if (rising)    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter, divided output and coefficient registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntr      <= '0;
            clk_out_q <= 1'b1;
            half_q    <= CNTR_WIDTH'(DEFAULT_HALF);
            pend_q    <= '0;
            pend_v    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= xfer && (cfg_half == '0);

            if (counting) begin
                if (boundary) begin
                    cntr      <= '0;
                    clk_out_q <= ~clk_out_q;
                end else begin
                    cntr <= cntr + CNTR_WIDTH'(1);
                end
            end else begin
                cntr      <= '0;
                clk_out_q <= 1'b1;
            end

            // A value parked while counting is never lost: it lands at the next
            // boundary, or immediately in IDLE if the final stop boundary raced it.
            if (!counting) begin
                if (pend_v) begin
                    half_q <= pend_q;
                    pend_v <= 1'b0;
                end else if (accept) begin
                    half_q <= cfg_half;
                end
            end else begin
                if (boundary && pend_v) begin
                    half_q <= pend_q;
                    pend_v <= 1'b0;
                end
                if (accept) begin
                    pend_q <= cfg_half;
                    pend_v <= 1'b1;
                end
            end
        end
    end

`ifdef FDC_PERIOD_CNT_EN
    logic [15:0] period_q;

    // Rising-edge period counter, cleared on each start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
        end else if ((state == IDLE) && (state_next == RUN)) begin
            period_q <= '0;
        end else if (rising) begin
            period_q <= period_q + 16'd1;
        end
    end

    // Period counter output
    always_comb begin
        period_cnt = period_q;
    end
`endif

    // Output decode
    always_comb begin
        running   = (state != IDLE);
        tick      = boundary;
        cfg_ready = !pend_v;
        cfg_err   = cfg_err_q;
        clk_out   = clk_out_q;
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed scenarios plus randomized stimulus checked
// against a phase-countdown reference model of freq_div_ctrl.
module tb_freq_div_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_half = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic         running;
`ifdef FDC_PERIOD_CNT_EN
    logic [15:0]  period_cnt;
`endif

    int checks = 0;
    int errors = 0;

    freq_div_ctrl #(
        .CNTR_WIDTH   (W),
        .DEFAULT_HALF (DEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
`ifdef FDC_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .tick       (tick),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=run 2=stopping; m_left counts down the
    // cycles left in the current output phase; pending loads sit in a queue.
    int  m_mode;
    int  m_left;
    bit  m_level;
    int  m_half;
    int  m_pend[$];
    bit  m_err;
    int  m_pc;

    always @(posedge clk or negedge rst) begin
        bit toggle_now;
        bit rise;
        bit x;
        int new_mode;
        int old_mode;
        if (!rst) begin
            m_mode  = 0;
            m_left  = 0;
            m_level = 1'b1;
            m_half  = DEF;
            m_pend.delete();
            m_err   = 1'b0;
            m_pc    = 0;
        end else begin
            old_mode   = m_mode;
            toggle_now = (m_mode != 0) && (m_left == 1);
            rise       = toggle_now && !m_level;
            x          = cfg_valid && (m_pend.size() == 0);
            m_err      = x && (cfg_half == 0);
            new_mode   = m_mode;
            case (m_mode)
                0: if (start && !stop) new_mode = 1;
                1: if (stop) new_mode = 2;
                default: begin
                    if (start && !stop) new_mode = 1;
                    else if (rise)      new_mode = 0;
                end
            endcase
            if (old_mode != 0) begin
                if (toggle_now) begin
                    m_level = !m_level;
                    if (m_pend.size() != 0) m_half = m_pend.pop_front();
                    m_left = m_half;
                    if (rise) m_pc = (m_pc + 1) % 65536;
                end else begin
                    m_left = m_left - 1;
                end
                if (x && cfg_half != 0) m_pend.push_back(int'(cfg_half));
            end else begin
                m_level = 1'b1;
                if (m_pend.size() != 0) m_half = m_pend.pop_front();
                else if (x && cfg_half != 0) m_half = int'(cfg_half);
            end
            if (old_mode == 0 && new_mode == 1) begin
                m_left = m_half;
                m_pc   = 0;
            end
            m_mode = new_mode;
        end
    end

    task automatic cfg_load(input int h);
        cfg_valid = 1'b1;
        cfg_half  = W'(h);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Leaves the bench at sample s_0: first negedge after RUN entry
    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_idle();
        int n;
        stop = 1'b1;
        n = 0;
        @(negedge clk);
        stop = 1'b0;
        while (running && n < 1100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (running !== 1'b0) begin
            $display("FAIL go_idle_timeout: running=%b required 0", running);
            errors++;
        end
        checks++;
        if (clk_out !== 1'b1) begin
            $display("FAIL go_idle_clk_out: clk_out=%b required 1", clk_out);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (clk_out !== 1'b1) begin $display("FAIL reset_clk_out: got %b required 1", clk_out); errors++; end
        checks++;
        if (cfg_ready !== 1'b1) begin $display("FAIL reset_cfg_ready: got %b required 1", cfg_ready); errors++; end
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL reset_cfg_err: got %b required 0", cfg_err); errors++; end
        checks++;
        if (tick !== 1'b0) begin $display("FAIL reset_tick: got %b required 0", tick); errors++; end
        checks++;
        if (running !== 1'b0) begin $display("FAIL reset_running: got %b required 0", running); errors++; end
`ifdef FDC_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd0) begin $display("FAIL reset_period_cnt: got %0d required 0", period_cnt); errors++; end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Checks n samples of the free-running waveform for half-period h from s_0
    task automatic test_period(input int h, input int n);
        bit exp_clk;
        bit exp_tick;
        for (int k = 0; k < n; k++) begin
            exp_clk  = ((k / h) % 2) == 0;
            exp_tick = (k % h) == (h - 1);
            checks++;
            if (clk_out !== exp_clk) begin
                $display("FAIL period_h%0d_clk_out k=%0d: got %b required %b", h, k, clk_out, exp_clk);
                errors++;
            end
            checks++;
            if (tick !== exp_tick) begin
                $display("FAIL period_h%0d_tick k=%0d: got %b required %b", h, k, tick, exp_tick);
                errors++;
            end
            checks++;
            if (running !== 1'b1) begin
                $display("FAIL period_h%0d_running k=%0d: got %b required 1", h, k, running);
                errors++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_default_run();
        start_run();
        test_period(DEF, 12);
        go_idle();
    endtask

    task automatic test_cfg_idle();
        cfg_load(5);
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL cfg5_err: got %b required 0", cfg_err); errors++; end
        checks++;
        if (cfg_ready !== 1'b1) begin $display("FAIL cfg5_ready: got %b required 1", cfg_ready); errors++; end
        cfg_valid = 1'b1;
        cfg_half  = '0;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin $display("FAIL cfg0_err_pulse: got %b required 1", cfg_err); errors++; end
        checks++;
        if (cfg_ready !== 1'b1) begin $display("FAIL cfg0_ready: got %b required 1", cfg_ready); errors++; end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL cfg0_err_width: got %b required 0", cfg_err); errors++; end
        start_run();
        test_period(5, 22);
        go_idle();
    endtask

    task automatic test_cfg_running();
        bit exp_clk [0:7];
        bit exp_tick[0:7];
        bit exp_rdy [0:7];
        exp_clk  = '{1, 1, 1, 0, 1, 0, 1, 0};
        exp_tick = '{0, 0, 1, 1, 1, 1, 1, 1};
        exp_rdy  = '{1, 0, 0, 1, 1, 1, 1, 1};
        cfg_load(3);
        start_run();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (clk_out !== exp_clk[k]) begin $display("FAIL cfgrun_clk_out k=%0d: got %b required %b", k, clk_out, exp_clk[k]); errors++; end
            checks++;
            if (tick !== exp_tick[k]) begin $display("FAIL cfgrun_tick k=%0d: got %b required %b", k, tick, exp_tick[k]); errors++; end
            checks++;
            if (cfg_ready !== exp_rdy[k]) begin $display("FAIL cfgrun_ready k=%0d: got %b required %b", k, cfg_ready, exp_rdy[k]); errors++; end
            cfg_valid = (k == 0);
            cfg_half  = W'(1);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        go_idle();
    endtask

    // stop raised at sample stop_k; the output must park on rising edge at park_k
    task automatic test_stop_at(input int stop_k, input int park_k, input int low_k);
        bit exp_clk;
        bit exp_run;
        cfg_load(4);
        start_run();
        for (int k = 0; k < park_k + 4; k++) begin
            exp_run = k < park_k;
            exp_clk = !(k >= low_k && k < park_k);
            checks++;
            if (clk_out !== exp_clk) begin $display("FAIL stop%0d_clk_out k=%0d: got %b required %b", stop_k, k, clk_out, exp_clk); errors++; end
            checks++;
            if (running !== exp_run) begin $display("FAIL stop%0d_running k=%0d: got %b required %b", stop_k, k, running, exp_run); errors++; end
            stop = (k == stop_k);
            @(negedge clk);
        end
        stop = 1'b0;
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (running !== 1'b0) begin $display("FAIL both_idle_running: got %b required 0", running); errors++; end
            checks++;
            if (clk_out !== 1'b1) begin $display("FAIL both_idle_clk_out: got %b required 1", clk_out); errors++; end
        end
        start = 1'b0;
        stop  = 1'b0;
        cfg_load(4);
        start_run();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (clk_out !== (((k / 4) % 2) == 0)) begin $display("FAIL resume_clk_out k=%0d: got %b required %b", k, clk_out, ((k / 4) % 2) == 0); errors++; end
            checks++;
            if (running !== 1'b1) begin $display("FAIL resume_running k=%0d: got %b required 1", k, running); errors++; end
            stop  = (k == 1);
            start = (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        go_idle();
    endtask

    task automatic test_reset_mid();
        cfg_load(3);
        start_run();
        for (int k = 0; k < 4; k++) begin
            cfg_valid = (k == 3);
            cfg_half  = W'(6);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin $display("FAIL rstmid_pending: cfg_ready=%b required 0", cfg_ready); errors++; end
        checks++;
        if (clk_out !== 1'b0) begin $display("FAIL rstmid_pre_low: clk_out=%b required 0", clk_out); errors++; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (clk_out !== 1'b1) begin $display("FAIL rstmid_clk_out: got %b required 1", clk_out); errors++; end
        checks++;
        if (cfg_ready !== 1'b1) begin $display("FAIL rstmid_cfg_ready: got %b required 1", cfg_ready); errors++; end
        checks++;
        if (running !== 1'b0) begin $display("FAIL rstmid_running: got %b required 0", running); errors++; end
        checks++;
        if (tick !== 1'b0) begin $display("FAIL rstmid_tick: got %b required 0", tick); errors++; end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_run();
        test_period(DEF, 8);
        go_idle();
    endtask

`ifdef FDC_PERIOD_CNT_EN
    task automatic test_period_cnt();
        cfg_load(2);
        start_run();
        checks++;
        if (period_cnt !== 16'd0) begin $display("FAIL pcnt_start: got %0d required 0", period_cnt); errors++; end
        repeat (12) @(negedge clk);
        checks++;
        if (period_cnt !== 16'd3) begin $display("FAIL pcnt_three: got %0d required 3", period_cnt); errors++; end
        go_idle();
        start_run();
        checks++;
        if (period_cnt !== 16'd0) begin $display("FAIL pcnt_restart: got %0d required 0", period_cnt); errors++; end
        go_idle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            checks++;
            if (clk_out !== m_level) begin $display("FAIL rand_clk_out i=%0d: got %b required %b", i, clk_out, m_level); errors++; end
            checks++;
            if (tick !== ((m_mode != 0) && (m_left == 1))) begin $display("FAIL rand_tick i=%0d: got %b required %b", i, tick, (m_mode != 0) && (m_left == 1)); errors++; end
            checks++;
            if (running !== (m_mode != 0)) begin $display("FAIL rand_running i=%0d: got %b required %b", i, running, m_mode != 0); errors++; end
            checks++;
            if (cfg_ready !== (m_pend.size() == 0)) begin $display("FAIL rand_cfg_ready i=%0d: got %b required %b", i, cfg_ready, m_pend.size() == 0); errors++; end
            checks++;
            if (cfg_err !== m_err) begin $display("FAIL rand_cfg_err i=%0d: got %b required %b", i, cfg_err, m_err); errors++; end
`ifdef FDC_PERIOD_CNT_EN
            checks++;
            if (period_cnt !== 16'(m_pc)) begin $display("FAIL rand_period_cnt i=%0d: got %0d required %0d", i, period_cnt, m_pc); errors++; end
`endif
            start     = ($urandom_range(0, 9) == 0);
            stop      = ($urandom_range(0, 13) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_half  = W'($urandom_range(0, 6));
            @(negedge clk);
        end
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        go_idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_default_run();
        test_cfg_idle();
        test_cfg_running();
        test_stop_at(1, 8, 4);
        test_stop_at(5, 8, 4);
        test_start_stop();
        test_reset_mid();
`ifdef FDC_PERIOD_CNT_EN
        test_period_cnt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
